// File: rtl/fp_mul_arb_pkg.sv
// Shared types and helpers for the round-robin shared fp32 multiplier front end.
package fp_mul_arb_pkg;

  localparam int FP_W     = 32;
  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;

  typedef logic [FP_W-1:0] fp32_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_ID_W-1:0] idx);
    onehot = {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/fp_mul_arb_if.sv
// Requester-side request/response channels of the shared multiplier.
interface fp_mul_arb_if #(parameter int N_REQ = 4);
  import fp_mul_arb_pkg::*;

  logic  [N_REQ-1:0] req_valid;
  logic  [N_REQ-1:0] req_ready;
  fp32_t [N_REQ-1:0] req_a;
  fp32_t [N_REQ-1:0] req_b;
  logic  [N_REQ-1:0] rsp_valid;
  logic  [N_REQ-1:0] rsp_ready;
  fp32_t             rsp_y;

  modport master (output req_valid, req_a, req_b, rsp_ready,
                  input  req_ready, rsp_valid, rsp_y);
  modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                  output req_ready, rsp_valid, rsp_y);
endinterface

// File: rtl/fp_mul.sv
// Combinational IEEE-754 single multiplier, round-to-nearest-even, subnormals flushed to zero.
module fp_mul
  import fp_mul_arb_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t y
);

  logic              sgn_s, g_s, st_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic [23:0]       ma_s, mb_s, rnd_s;
  logic [47:0]       prod_s;
  logic [22:0]       frac_s;
  logic signed [9:0] exp_s;

  // Mantissa product, normalise by one bit, round, then classify specials.
  always_comb begin
    sgn_s    = a[31] ^ b[31];
    a_zero_s = (a[30:23] == 8'd0);
    b_zero_s = (b[30:23] == 8'd0);
    a_inf_s  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf_s  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan_s  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan_s  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ma_s     = {1'b1, a[22:0]};
    mb_s     = {1'b1, b[22:0]};
    prod_s   = ma_s * mb_s;
    exp_s    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod_s[47]) begin
      frac_s = prod_s[46:24];
      g_s    = prod_s[23];
      st_s   = |prod_s[22:0];
      exp_s  = exp_s + 10'sd1;
    end else begin
      frac_s = prod_s[45:23];
      g_s    = prod_s[22];
      st_s   = |prod_s[21:0];
    end
    rnd_s = {1'b0, frac_s} + {23'd0, g_s & (st_s | frac_s[0])};
    if (rnd_s[23]) begin
      exp_s = exp_s + 10'sd1;
    end else begin
      exp_s = exp_s;
    end
    if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
      y = {1'b0, 8'hFF, 23'h400000};
    end else if (a_inf_s || b_inf_s) begin
      y = {sgn_s, 8'hFF, 23'd0};
    end else if (a_zero_s || b_zero_s || (exp_s <= 10'sd0)) begin
      y = {sgn_s, 31'd0};
    end else if (exp_s >= 10'sd255) begin
      y = {sgn_s, 8'hFF, 23'd0};
    end else begin
      y = {sgn_s, exp_s[7:0], rnd_s[22:0]};
    end
  end

endmodule

// File: rtl/fp_mul_arb_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);

  int             sum_s;
  logic [IDW-1:0] cand_s;
  logic           hit_s;

  // Scan N positions starting at ptr; the first request found wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum_s   = 0;
    cand_s  = '0;
    hit_s   = 1'b0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        sum_s        = int'(ptr) + i;
        cand_s       = (sum_s >= N) ? IDW'(sum_s - N) : IDW'(sum_s);
        hit_s        = !any && req[cand_s];
        gnt[cand_s]  = gnt[cand_s] | hit_s;
        gnt_idx      = hit_s ? cand_s : gnt_idx;
        any          = any | hit_s;
      end
    end else begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
    end
  end

endmodule

// File: rtl/fp_mul_arb.sv
// Round-robin sharing of one fp_mul among N_REQ requesters through an operand and a result register.
module fp_mul_arb
  import fp_mul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_mul_arb_if.slave      bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic             s1_vld_q, s1_vld_d;
  fp32_t            s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  fp32_t            s2_y_q, s2_y_d;
  logic [ID_W-1:0]  s2_id_q, s2_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             busy_q, busy_d;

  logic               s2_vld_s, rsp_hs_s, s2_adv_s, s1_adv_s, arb_en_s, gnt_any_s;
  logic [N_REQ-1:0]   gnt_s;
  logic [ID_W-1:0]    gnt_idx_s;
  logic [MAX_REQ-1:0] oh_s;
  fp32_t              mul_y_s;

  assign s2_vld_s = |rsp_valid_q;
  assign rsp_hs_s = s2_vld_s & bus.rsp_ready[s2_id_q];
  assign s2_adv_s = !s2_vld_s | rsp_hs_s;
  assign s1_adv_s = !s1_vld_q | s2_adv_s;
  // No grant may escape while reset is asserted.
  assign arb_en_s = s1_adv_s & rst_n;

  rr_arb #(.N(N_REQ), .IDW(ID_W)) u_rr_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .en      (arb_en_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any     (gnt_any_s)
  );

  fp_mul u_fp_mul (.a(s1_a_q), .b(s1_b_q), .y(mul_y_s));

  assign bus.req_ready = gnt_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = s2_y_q;
  assign busy          = busy_q;
  assign op_count      = op_count_q;

  // Next-state for both pipeline stages, the round-robin pointer and the counter.
  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = rsp_valid_q;
    s2_y_d      = s2_y_q;
    s2_id_d     = s2_id_q;
    rr_ptr_d    = rr_ptr_q;
    oh_s        = onehot(MAX_ID_W'(s1_id_q));
    if (s2_adv_s) begin
      rsp_valid_d = s1_vld_q ? oh_s[N_REQ-1:0] : {N_REQ{1'b0}};
      s2_y_d      = mul_y_s;
      s2_id_d     = s1_id_q;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
    if (s1_adv_s && gnt_any_s) begin
      s1_vld_d = 1'b1;
      s1_a_d   = bus.req_a[gnt_idx_s];
      s1_b_d   = bus.req_b[gnt_idx_s];
      s1_id_d  = gnt_idx_s;
      rr_ptr_d = (gnt_idx_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : gnt_idx_s + ID_W'(1);
    end else if (s1_adv_s) begin
      s1_vld_d = 1'b0;
    end else begin
      s1_vld_d = s1_vld_q;
    end
    op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, rsp_hs_s};
    busy_d     = s1_vld_d | (|rsp_valid_d);
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= '0;
      s2_y_q      <= '0;
      s2_id_q     <= '0;
      rr_ptr_q    <= '0;
      op_count_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      s2_y_q      <= s2_y_d;
      s2_id_q     <= s2_id_d;
      rr_ptr_q    <= rr_ptr_d;
      op_count_q  <= op_count_d;
      busy_q      <= busy_d;
    end
  end

endmodule
